// File: rtl/branch_predict_gshare.sv
// Global-history / gshare branch predictor with speculative history,
// per-branch snapshots carried to M, misprediction repair and perf counters.
module branch_predict_gshare #(
  parameter int GHR_BITS  = 8,
  parameter int PHT_IDX   = 10,
  parameter int CNT_BITS  = 2,
  parameter int HASH_MODE = 1,
  parameter int PC_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallD,
  input  logic                flushD,
  input  logic                flushE,
  input  logic                flushM,
  input  logic                branchD,
  input  logic [PC_W-1:0]     pcD,
  input  logic                branchM,
  input  logic                actual_takeM,
  output logic                pred_takeD,
  output logic                pred_takeM,
  output logic                pred_wrongM,
  output logic [GHR_BITS-1:0] ghr_spec,
  output logic [31:0]         branch_cnt,
  output logic [31:0]         mispred_cnt
);

  localparam int Depth = 2 ** PHT_IDX;
  localparam logic [CNT_BITS-1:0] CntInit = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);
  localparam logic [CNT_BITS-1:0] CntMax  = '1;
  localparam logic [CNT_BITS-1:0] CntOne  = CNT_BITS'(1);

  logic [CNT_BITS-1:0] pht [Depth];

  logic [GHR_BITS-1:0] sGhr;
  logic [GHR_BITS-1:0] rGhr;
  logic [PHT_IDX-1:0]  ghrIdx;
  logic [PHT_IDX-1:0]  idxD;

  logic                brE;
  logic                predE;
  logic [PHT_IDX-1:0]  idxE;
  logic [GHR_BITS-1:0] ghrE;
  logic                brM;
  logic                predM;
  logic [PHT_IDX-1:0]  idxM;
  logic [GHR_BITS-1:0] ghrM;

  logic [CNT_BITS-1:0] cntM;
  logic                unusedBits;

  // Truncating cast drops the oldest bit; also valid for 1-bit history.
  function automatic logic [GHR_BITS-1:0] shiftIn(
    input logic [GHR_BITS-1:0] h,
    input logic                b
  );
    return GHR_BITS'({h, b});
  endfunction

  assign ghrIdx = PHT_IDX'(sGhr);

  generate
    if (HASH_MODE != 0) begin : gHash
      assign idxD = pcD[PHT_IDX+1:2] ^ ghrIdx;
    end else begin : gGlobal
      assign idxD = ghrIdx;
    end
  endgenerate

  assign pred_takeD  = branchD & pht[idxD][CNT_BITS-1];
  assign pred_takeM  = predM;
  assign pred_wrongM = branchM & (predM ^ actual_takeM);
  assign ghr_spec    = sGhr;
  assign cntM        = pht[idxM];
  assign unusedBits  = ^{pcD, rGhr, brM};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) pht[i] <= CntInit;
    end else if (branchM) begin
      if (actual_takeM && cntM != CntMax)
        pht[idxM] <= cntM + CntOne;
      else if (!actual_takeM && cntM != '0)
        pht[idxM] <= cntM - CntOne;
    end
  end

  // Repair wins over a same-cycle speculative shift from D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sGhr <= '0;
    end else if (pred_wrongM) begin
      sGhr <= shiftIn(ghrM, actual_takeM);
    end else if (branchD && !stallD && !flushD) begin
      sGhr <= shiftIn(sGhr, pred_takeD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rGhr <= '0;
    else if (branchM) rGhr <= shiftIn(rGhr, actual_takeM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brE   <= 1'b0;
      predE <= 1'b0;
      idxE  <= '0;
      ghrE  <= '0;
    end else if (flushE) begin
      brE   <= 1'b0;
      predE <= 1'b0;
      idxE  <= '0;
      ghrE  <= '0;
    end else begin
      brE   <= branchD;
      predE <= pred_takeD;
      idxE  <= idxD;
      ghrE  <= sGhr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brM   <= 1'b0;
      predM <= 1'b0;
      idxM  <= '0;
      ghrM  <= '0;
    end else if (flushM) begin
      brM   <= 1'b0;
      predM <= 1'b0;
      idxM  <= '0;
      ghrM  <= '0;
    end else begin
      brM   <= brE;
      predM <= predE;
      idxM  <= idxE;
      ghrM  <= ghrE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branchM && branch_cnt != '1)
        branch_cnt <= branch_cnt + 32'd1;
      if (pred_wrongM && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Bench for branch_predict_gshare: global-only (u0) and gshare (u1)
// instances share stimulus and are compared against a behavioural model.
module tb_branch_predict_gshare;

  localparam int GB   = 4;
  localparam int PI   = 10;
  localparam int CB   = 2;
  localparam int GM   = (1 << GB) - 1;
  localparam int NPHT = 1 << PI;
  localparam longint SAT = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0, flushD = 1'b0, flushE = 1'b0, flushM = 1'b0;
  logic        branchD = 1'b0, branchM = 1'b0, actual_takeM = 1'b0;
  logic [31:0] pcD = '0;

  logic [1:0]    ptD, ptM, pwM;
  logic [GB-1:0] gs [2];
  logic [31:0]   bcnt [2];
  logic [31:0]   mcnt [2];

  int nChk = 0;
  int nPass = 0;

  always #5 clk = ~clk;

  branch_predict_gshare #(
    .GHR_BITS(GB), .PHT_IDX(PI), .CNT_BITS(CB),
    .HASH_MODE(0), .PC_W(32)
  ) u0 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .branchD(branchD), .pcD(pcD),
    .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(ptD[0]), .pred_takeM(ptM[0]), .pred_wrongM(pwM[0]),
    .ghr_spec(gs[0]), .branch_cnt(bcnt[0]), .mispred_cnt(mcnt[0])
  );

  branch_predict_gshare #(
    .GHR_BITS(GB), .PHT_IDX(PI), .CNT_BITS(CB),
    .HASH_MODE(1), .PC_W(32)
  ) u1 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .branchD(branchD), .pcD(pcD),
    .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeD(ptD[1]), .pred_takeM(ptM[1]), .pred_wrongM(pwM[1]),
    .ghr_spec(gs[1]), .branch_cnt(bcnt[1]), .mispred_cnt(mcnt[1])
  );

  // Reference model: counters as ints, history as an int, pipeline as slots.
  int     mPht [2][NPHT];
  int     mSg [2];
  longint mBc [2];
  longint mMc [2];
  int     ePr [2], eIx [2], eGh [2];
  int     mPr [2], mIx [2], mGh [2];
  bit     eBr, mBr;
  int     curIdx [2];
  bit     expPtD [2], expPtM [2], expPwM [2];

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NPHT; i++) mPht[m][i] = 1;
      mSg[m] = 0; mBc[m] = 0; mMc[m] = 0;
      ePr[m] = 0; eIx[m] = 0; eGh[m] = 0;
      mPr[m] = 0; mIx[m] = 0; mGh[m] = 0;
    end
    eBr = 0; mBr = 0;
  endfunction

  task automatic setIn(input bit b, input logic [31:0] pc,
                       input bit st, input bit fd, input bit fe,
                       input bit fm, input bit a);
    branchD = b; pcD = pc; stallD = st; flushD = fd;
    flushE = fe; flushM = fm;
    branchM = mBr; actual_takeM = a & mBr;
    for (int m = 0; m < 2; m++) begin
      curIdx[m] = (m == 1 ? int'(pc[PI+1:2]) : 0) ^ mSg[m];
      expPtD[m] = b && (mPht[m][curIdx[m]] >= 2);
      expPtM[m] = (mPr[m] != 0);
      expPwM[m] = mBr && ((mPr[m] != 0) != (a & mBr));
    end
    #1;
  endtask

  task automatic tick();
    int old;
    bit act;
    @(posedge clk);
    act = actual_takeM;
    for (int m = 0; m < 2; m++) begin
      old = mSg[m];
      if (mBr) begin
        if (act) mPht[m][mIx[m]] = (mPht[m][mIx[m]] == 3) ? 3 : mPht[m][mIx[m]] + 1;
        else     mPht[m][mIx[m]] = (mPht[m][mIx[m]] == 0) ? 0 : mPht[m][mIx[m]] - 1;
        if (mBc[m] < SAT) mBc[m]++;
      end
      if (expPwM[m] && mMc[m] < SAT) mMc[m]++;
      if (expPwM[m]) mSg[m] = ((mGh[m] << 1) | int'(act)) & GM;
      else if (branchD && !stallD && !flushD)
        mSg[m] = ((old << 1) | int'(expPtD[m])) & GM;
      mPr[m] = flushM ? 0 : ePr[m];
      mIx[m] = flushM ? 0 : eIx[m];
      mGh[m] = flushM ? 0 : eGh[m];
      ePr[m] = flushE ? 0 : int'(expPtD[m]);
      eIx[m] = flushE ? 0 : curIdx[m];
      eGh[m] = flushE ? 0 : old;
    end
    mBr = flushM ? 1'b0 : eBr;
    eBr = flushE ? 1'b0 : branchD;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    branchD = 0; pcD = '0; stallD = 0; flushD = 0;
    flushE = 0; flushM = 0; branchM = 0; actual_takeM = 0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runBranch(input logic [31:0] pc, input bit a);
    setIn(1, pc, 0, 0, 0, 0, 0); tick();
    setIn(0, '0, 0, 0, 0, 0, 0); tick();
    setIn(0, '0, 0, 0, 0, 0, a); tick();
  endtask

  task automatic appendBit(input bit v, input int tgt);
    runBranch(32'((tgt ^ mSg[1]) << 2), v);
  endtask

  task automatic test_reset();
    int bad;
    for (int i = 0; i < 12; i++) begin
      setIn(1, $urandom, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      tick();
    end
    setIn(1, $urandom, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    modelReset();
    branchM = 0; actual_takeM = 0;
    #1;
    for (int m = 0; m < 2; m++) begin
      nChk++; if (ptD[m] !== 1'b0) $display("FAIL rst_predD[%0d] got %b want 0", m, ptD[m]); else nPass++;
      nChk++; if (ptM[m] !== 1'b0) $display("FAIL rst_predM[%0d] got %b want 0", m, ptM[m]); else nPass++;
      nChk++; if (pwM[m] !== 1'b0) $display("FAIL rst_wrongM[%0d] got %b want 0", m, pwM[m]); else nPass++;
      nChk++; if (gs[m] !== '0) $display("FAIL rst_ghr[%0d] got %h want 0", m, gs[m]); else nPass++;
      nChk++; if (bcnt[m] !== 32'd0) $display("FAIL rst_bcnt[%0d] got %0d want 0", m, bcnt[m]); else nPass++;
      nChk++; if (mcnt[m] !== 32'd0) $display("FAIL rst_mcnt[%0d] got %0d want 0", m, mcnt[m]); else nPass++;
    end
    @(negedge clk);
    rst = 1'b0; branchD = 0;
    #1;
    bad = 0;
    for (int i = 0; i < NPHT; i++) if (u0.pht[i] !== 2'd1) bad++;
    nChk++; if (bad != 0) $display("FAIL rst_pht0 got %0d bad entries want 0", bad); else nPass++;
    bad = 0;
    for (int i = 0; i < NPHT; i++) if (u1.pht[i] !== 2'd1) bad++;
    nChk++; if (bad != 0) $display("FAIL rst_pht1 got %0d bad entries want 0", bad); else nPass++;
    @(negedge clk);
  endtask

  task automatic test_first_branch();
    doReset();
    setIn(1, 32'h40, 0, 0, 0, 0, 0);
    nChk++; if (ptD[1] !== 1'b0) $display("FAIL first_predD got %b want 0", ptD[1]); else nPass++;
    tick();
    setIn(0, '0, 0, 0, 0, 0, 0); tick();
    setIn(0, '0, 0, 0, 0, 0, 1);
    nChk++; if (pwM[1] !== 1'b1) $display("FAIL first_wrongM got %b want 1", pwM[1]); else nPass++;
    tick();
    nChk++; if (mcnt[1] !== 32'd1) $display("FAIL first_mcnt got %0d want 1", mcnt[1]); else nPass++;
    nChk++; if (bcnt[1] !== 32'd1) $display("FAIL first_bcnt got %0d want 1", bcnt[1]); else nPass++;
    nChk++; if (gs[1] !== 4'b0001) $display("FAIL first_ghr got %b want 0001", gs[1]); else nPass++;
    nChk++; if (u1.pht[16] !== 2'd2) $display("FAIL first_pht got %0d want 2", u1.pht[16]); else nPass++;
  endtask

  task automatic test_saturation();
    int pd [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    int cv [8] = '{2, 3, 3, 3, 2, 1, 0, 0};
    doReset();
    for (int i = 0; i < 8; i++) begin
      setIn(1, 32'((341 ^ mSg[1]) << 2), 0, 0, 0, 0, 0);
      nChk++; if (ptD[1] !== 1'(pd[i])) $display("FAIL sat_predD[%0d] got %b want %0d", i, ptD[1], pd[i]); else nPass++;
      tick();
      setIn(0, '0, 0, 0, 0, 0, 0); tick();
      setIn(0, '0, 0, 0, 0, 0, i < 4); tick();
      nChk++; if (u1.pht[341] !== 2'(cv[i])) $display("FAIL sat_cnt[%0d] got %0d want %0d", i, u1.pht[341], cv[i]); else nPass++;
    end
  endtask

  task automatic test_repair();
    doReset();
    appendBit(0, 'h200);
    appendBit(1, 'h201);
    appendBit(1, 'h202);
    appendBit(0, 'h203);
    nChk++; if (gs[1] !== 4'b0110) $display("FAIL rep_setup got %b want 0110", gs[1]); else nPass++;
    setIn(1, 32'(('h3F0 ^ mSg[1]) << 2), 0, 0, 0, 0, 0); tick();
    setIn(0, '0, 0, 0, 0, 0, 0); tick();
    setIn(1, 32'h0000_0ABC, 0, 0, 0, 0, 1);
    nChk++; if (pwM[1] !== 1'b1) $display("FAIL rep_wrongM got %b want 1", pwM[1]); else nPass++;
    tick();
    nChk++; if (gs[1] !== 4'b1101) $display("FAIL rep_ghr1 got %b want 1101", gs[1]); else nPass++;
    nChk++; if (gs[0] !== 4'b1101) $display("FAIL rep_ghr0 got %b want 1101", gs[0]); else nPass++;
  endtask

  task automatic test_alias();
    doReset();
    runBranch(32'h40, 1);
    for (int i = 0; i < 4; i++) appendBit(0, 'h300 + i);
    nChk++; if (gs[0] !== 4'b0000) $display("FAIL alias_ghr0 got %b want 0000", gs[0]); else nPass++;
    nChk++; if (gs[1] !== 4'b0000) $display("FAIL alias_ghr1 got %b want 0000", gs[1]); else nPass++;
    runBranch(32'h80, 1);
    nChk++; if (u0.pht[0] !== 2'd3) $display("FAIL alias_g0 got %0d want 3", u0.pht[0]); else nPass++;
    nChk++; if (u1.pht[16] !== 2'd2) $display("FAIL alias_h10 got %0d want 2", u1.pht[16]); else nPass++;
    nChk++; if (u1.pht[32] !== 2'd2) $display("FAIL alias_h20 got %0d want 2", u1.pht[32]); else nPass++;
  endtask

  task automatic test_stall_flush();
    logic [31:0] pc;
    doReset();
    appendBit(1, 'h100);
    pc = 32'(('h100 ^ mSg[1]) << 2);
    for (int i = 0; i < 3; i++) begin
      setIn(1, pc, 1, 0, 1, 0, 0);
      nChk++; if (ptD[1] !== 1'b1) $display("FAIL stall_predD[%0d] got %b want 1", i, ptD[1]); else nPass++;
      nChk++; if (gs[1] !== 4'b0001) $display("FAIL stall_ghr[%0d] got %b want 0001", i, gs[1]); else nPass++;
      tick();
    end
    nChk++; if (gs[1] !== 4'b0001) $display("FAIL stall_ghr_end got %b want 0001", gs[1]); else nPass++;
    setIn(1, pc, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      setIn(0, '0, 0, 0, 0, 0, 1); tick();
    end
    nChk++; if (bcnt[1] !== 32'd1) $display("FAIL flushE_bcnt1 got %0d want 1", bcnt[1]); else nPass++;
    nChk++; if (bcnt[0] !== 32'd1) $display("FAIL flushE_bcnt0 got %0d want 1", bcnt[0]); else nPass++;
  endtask

  task automatic test_back_to_back();
    bit b, st, fd, fe, fm, a;
    doReset();
    for (int i = 0; i < 600; i++) begin
      b  = 1'($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      fd = ($urandom_range(0, 9) == 0);
      fe = st | ($urandom_range(0, 9) == 0);
      fm = ($urandom_range(0, 9) == 0);
      a  = 1'($urandom_range(0, 1));
      setIn(b, $urandom & 32'h0000_0FFC, st, fd, fe, fm, a);
      for (int m = 0; m < 2; m++) begin
        nChk++; if (ptD[m] !== expPtD[m]) $display("FAIL rnd_predD[%0d] @%0d got %b want %b", m, i, ptD[m], expPtD[m]); else nPass++;
        nChk++; if (ptM[m] !== expPtM[m]) $display("FAIL rnd_predM[%0d] @%0d got %b want %b", m, i, ptM[m], expPtM[m]); else nPass++;
        nChk++; if (pwM[m] !== expPwM[m]) $display("FAIL rnd_wrongM[%0d] @%0d got %b want %b", m, i, pwM[m], expPwM[m]); else nPass++;
        nChk++; if (gs[m] !== GB'(mSg[m])) $display("FAIL rnd_ghr[%0d] @%0d got %h want %h", m, i, gs[m], mSg[m]); else nPass++;
        nChk++; if (bcnt[m] !== mBc[m][31:0]) $display("FAIL rnd_bcnt[%0d] @%0d got %0d want %0d", m, i, bcnt[m], mBc[m]); else nPass++;
        nChk++; if (mcnt[m] !== mMc[m][31:0]) $display("FAIL rnd_mcnt[%0d] @%0d got %0d want %0d", m, i, mcnt[m], mMc[m]); else nPass++;
      end
      tick();
    end
  endtask

  initial begin
    doReset();
    test_reset();
    test_first_branch();
    test_saturation();
    test_repair();
    test_alias();
    test_stall_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
